mem_port_arbiter: RTL and testbench

- Shares the single-port synchronous memory between two requesters: Port A (CPU sequence control, fetch and load/store) and Port B (external loader/debug DMA, e.g. a program bootloader).
- Each grant is one access cycle. Back-to-back accesses are allowed. Port B may lock the memory for bursts, with a starvation limit.
- Sits between the CPU/loader and the Memory module.
- Drives CPU_Stall so the sequence controller can hold state while it waits.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/arb_burst_counter.sv | 35 +++
 rtl/mem_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the memory port arbiter.
// Holds the ownership state encoding and the last-owner constants.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        OWN_A = 2'b01,
        OWN_B = 2'b10
    } arb_state_t;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

endpackage

// File: rtl/arb_burst_counter.sv
// arb_burst_counter: counts locked Port B accesses made while Port A waits.
// limit is raised when the access in progress brings the count to MaxBurst,
// so the owner FSM hands over right after the MaxBurst-th locked access.
module arb_burst_counter
    import mem_arb_pkg::*;
#(
    parameter int MaxBurst = 4,
    parameter int CntWidth = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic limit
);

    logic [CntWidth-1:0] count;
    logic [CntWidth:0]   count_after;

    // Include the access happening this cycle in the limit test.
    assign count_after = {1'b0, count} + {{CntWidth{1'b0}}, inc};
    assign limit       = (count_after >= (CntWidth + 1)'(MaxBurst));

    // Burst count: cleared when unlocked or outside OWN_B, saturating increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous memory between
// Port A (CPU fetch/load/store) and Port B (loader / debug DMA).
// Each grant is one memory cycle; acks follow their grant by one cycle.
// Port A never holds ownership, so the ports alternate under contention;
// Port B may hold via B_Lock for at most MaxBurst accesses while A waits.
// Build option ARB_ROUND_ROBIN_EN: contention seen in IDLE goes to the port
// that did not own the previous access (default build: Port A wins).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter int AddrWidth = 8,
    parameter int MaxBurst  = 4,
    parameter int CntWidth  = 8
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 A_Req,
    input  logic                 A_Wr,
    input  logic [AddrWidth-1:0] A_Addr,
    input  logic [DataWidth-1:0] A_DIn,
    output logic                 A_Gnt,
    output logic                 A_Ack,
    output logic [DataWidth-1:0] A_DOut,
    output logic                 CPU_Stall,
    input  logic                 B_Req,
    input  logic                 B_Wr,
    input  logic [AddrWidth-1:0] B_Addr,
    input  logic [DataWidth-1:0] B_DIn,
    input  logic                 B_Lock,
    output logic                 B_Gnt,
    output logic                 B_Ack,
    output logic [DataWidth-1:0] B_DOut,
    output logic [AddrWidth-1:0] Mem_Address,
    output logic [DataWidth-1:0] Mem_DIn,
    output logic                 Mem_Write_EN,
    output logic                 Mem_En,
    input  logic [DataWidth-1:0] Mem_DOut
);

    arb_state_t state;
    logic       last_owner;
    logic       ack_a_q;
    logic       ack_b_q;
    logic       sel_wr;
    logic       burst_inc;
    logic       burst_clear;
    logic       burst_limit;
    logic       b_hold;

    // A grant needs both ownership and a live request; a dropped request
    // leaves the owner in place but produces no memory cycle.
    assign A_Gnt     = (state == OWN_A) & A_Req;
    assign B_Gnt     = (state == OWN_B) & B_Req;
    assign CPU_Stall = A_Req & ~A_Gnt;

    assign Mem_En       = A_Gnt | B_Gnt;
    assign Mem_Write_EN = Mem_En & sel_wr;

    assign A_Ack  = ack_a_q;
    assign B_Ack  = ack_b_q;
    assign A_DOut = ack_a_q ? Mem_DOut : '0;
    assign B_DOut = ack_b_q ? Mem_DOut : '0;

    // Route the granted port's request onto the memory bus; idle bus reads as zero.
    always_comb begin
        Mem_Address = '0;
        Mem_DIn     = '0;
        sel_wr      = 1'b0;
        if (A_Gnt) begin
            Mem_Address = A_Addr;
            Mem_DIn     = A_DIn;
            sel_wr      = A_Wr;
        end else if (B_Gnt) begin
            Mem_Address = B_Addr;
            Mem_DIn     = B_DIn;
            sel_wr      = B_Wr;
        end
    end

    // Only locked B accesses that keep A waiting count toward the burst limit.
    assign burst_inc   = B_Gnt & A_Req & B_Lock;
    assign burst_clear = (state != OWN_B) | ~B_Lock;
    assign b_hold      = B_Lock & B_Req & ~burst_limit;

    arb_burst_counter #(
        .MaxBurst (MaxBurst),
        .CntWidth (CntWidth)
    ) u_burst (
        .clk   (Clk),
        .rst_n (Reset),
        .clear (burst_clear),
        .inc   (burst_inc),
        .limit (burst_limit)
    );

`ifndef ARB_ROUND_ROBIN_EN
    // The owner history is kept in every build; only round-robin reads it.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    // Ownership FSM with registered acks and last-owner history.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            last_owner <= OWNER_B;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
        end else begin
            ack_a_q <= A_Gnt;
            ack_b_q <= B_Gnt;
            if (A_Gnt) begin
                last_owner <= OWNER_A;
            end else if (B_Gnt) begin
                last_owner <= OWNER_B;
            end

            case (state)
                IDLE: begin
                    if (A_Req && B_Req) begin
`ifdef ARB_ROUND_ROBIN_EN
                        state <= (last_owner == OWNER_A) ? OWN_B : OWN_A;
`else
                        state <= OWN_A;
`endif
                    end else if (A_Req) begin
                        state <= OWN_A;
                    end else if (B_Req) begin
                        state <= OWN_B;
                    end else begin
                        state <= IDLE;
                    end
                end
                OWN_A: begin
                    // A never holds: a waiting B always takes the next cycle.
                    if (B_Req) begin
                        state <= OWN_B;
                    end else if (A_Req) begin
                        state <= OWN_A;
                    end else begin
                        state <= IDLE;
                    end
                end
                OWN_B: begin
                    if (A_Req && !b_hold) begin
                        state <= OWN_A;
                    end else if (B_Req) begin
                        state <= OWN_B;
                    end else if (A_Req) begin
                        state <= OWN_A;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic for
// mem_port_arbiter, checked against a cycle-level ownership model and a
// reference copy of memory contents kept inside the bench.
module tb_mem_port_arbiter;

    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int MAXB = 4;
    localparam int CW   = 8;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          Clk;
    logic          Reset;
    logic          A_Req, A_Wr;
    logic [AW-1:0] A_Addr;
    logic [DW-1:0] A_DIn;
    logic          A_Gnt, A_Ack;
    logic [DW-1:0] A_DOut;
    logic          CPU_Stall;
    logic          B_Req, B_Wr, B_Lock;
    logic [AW-1:0] B_Addr;
    logic [DW-1:0] B_DIn;
    logic          B_Gnt, B_Ack;
    logic [DW-1:0] B_DOut;
    logic [AW-1:0] Mem_Address;
    logic [DW-1:0] Mem_DIn;
    logic          Mem_Write_EN, Mem_En;
    logic [DW-1:0] Mem_DOut;

    int total;
    int bad;

    mem_port_arbiter #(
        .DataWidth (DW),
        .AddrWidth (AW),
        .MaxBurst  (MAXB),
        .CntWidth  (CW)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .A_Req        (A_Req),
        .A_Wr         (A_Wr),
        .A_Addr       (A_Addr),
        .A_DIn        (A_DIn),
        .A_Gnt        (A_Gnt),
        .A_Ack        (A_Ack),
        .A_DOut       (A_DOut),
        .CPU_Stall    (CPU_Stall),
        .B_Req        (B_Req),
        .B_Wr         (B_Wr),
        .B_Addr       (B_Addr),
        .B_DIn        (B_DIn),
        .B_Lock       (B_Lock),
        .B_Gnt        (B_Gnt),
        .B_Ack        (B_Ack),
        .B_DOut       (B_DOut),
        .Mem_Address  (Mem_Address),
        .Mem_DIn      (Mem_DIn),
        .Mem_Write_EN (Mem_Write_EN),
        .Mem_En       (Mem_En),
        .Mem_DOut     (Mem_DOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic logic [7:0] seed(int i);
        return (i == 16) ? 8'h5A : 8'(i * 7 + 3);
    endfunction

    // Single-port synchronous memory, one-cycle read latency; a write cycle
    // presents the written data on DOut.
    logic [7:0] mem [0:255];
    logic [7:0] mem_rdata;
    logic       mem_load;
    always @(posedge Clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= seed(i);
            mem_rdata <= '0;
        end else if (Mem_En) begin
            if (Mem_Write_EN) begin
                mem[Mem_Address] <= Mem_DIn;
                mem_rdata        <= Mem_DIn;
            end else begin
                mem_rdata <= mem[Mem_Address];
            end
        end
    end
    assign Mem_DOut = mem_rdata;

    // Reference model: owner 0=nobody, 1=A, 2=B; streak = locked B accesses
    // made while A was waiting.
    int         own;
    bit         last_b;
    int         streak;
    bit         ack_a_m, ack_b_m;
    logic [7:0] pend_a, pend_b;
    logic [7:0] ref_mem [0:255];
    logic       e_ga, e_gb, e_en, e_we, e_ack_a, e_ack_b, e_stall;
    logic [7:0] e_addr, e_din, e_dout_a, e_dout_b;

    task automatic model_reset();
        own = 0; last_b = 1'b1; streak = 0;
        ack_a_m = 1'b0; ack_b_m = 1'b0; pend_a = '0; pend_b = '0;
    endtask

    task automatic model_eval();
        e_ga     = (own == 1) && A_Req;
        e_gb     = (own == 2) && B_Req;
        e_en     = e_ga || e_gb;
        e_addr   = e_ga ? A_Addr : (e_gb ? B_Addr : 8'h00);
        e_din    = e_ga ? A_DIn : (e_gb ? B_DIn : 8'h00);
        e_we     = e_ga ? A_Wr : (e_gb ? B_Wr : 1'b0);
        e_ack_a  = ack_a_m;
        e_ack_b  = ack_b_m;
        e_dout_a = ack_a_m ? pend_a : 8'h00;
        e_dout_b = ack_b_m ? pend_b : 8'h00;
        e_stall  = A_Req && !e_ga;
    endtask

    task automatic model_next();
        int  sa;
        int  nxt;
        bit  keep;
        model_eval();
        sa = streak + ((e_gb && A_Req && B_Lock) ? 1 : 0);
        nxt = 0;
        if (own == 0) begin
            if (A_Req && B_Req) nxt = RR ? (last_b ? 1 : 2) : 1;
            else if (A_Req) nxt = 1;
            else if (B_Req) nxt = 2;
        end else if (own == 1) begin
            nxt = B_Req ? 2 : (A_Req ? 1 : 0);
        end else begin
            keep = B_Lock && B_Req && (sa < MAXB);
            if (A_Req && !keep) nxt = 1;
            else if (B_Req) nxt = 2;
            else if (A_Req) nxt = 1;
        end
        if (e_ga) begin
            pend_a = A_Wr ? A_DIn : ref_mem[A_Addr];
            if (A_Wr) ref_mem[A_Addr] = A_DIn;
            last_b = 1'b0;
        end
        if (e_gb) begin
            pend_b = B_Wr ? B_DIn : ref_mem[B_Addr];
            if (B_Wr) ref_mem[B_Addr] = B_DIn;
            last_b = 1'b1;
        end
        ack_a_m = e_ga;
        ack_b_m = e_gb;
        streak  = (own == 2 && nxt == 2 && B_Lock) ? sa : 0;
        own     = nxt;
    endtask

    task automatic step();
        model_next();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_cycles(int n);
        A_Req = 1'b0; B_Req = 1'b0; B_Lock = 1'b0;
        repeat (n) step();
    endtask

    task automatic test_reset();
        total++; if ({A_Gnt, B_Gnt, A_Ack, B_Ack, Mem_En, Mem_Write_EN} !== 6'b0) begin
            bad++; $display("FAIL rst_ctrl got=%b exp=000000", {A_Gnt, B_Gnt, A_Ack, B_Ack, Mem_En, Mem_Write_EN}); end
        total++; if ({Mem_Address, Mem_DIn, A_DOut, B_DOut} !== 32'h0) begin
            bad++; $display("FAIL rst_bus got=%h exp=0", {Mem_Address, Mem_DIn, A_DOut, B_DOut}); end
        @(negedge Clk); Reset = 1'b1;
        @(posedge Clk); #1;
        A_Req = 1'b1; A_Wr = 1'b0; A_Addr = 8'h10;
        model_eval(); @(negedge Clk);
        total++; if (A_Gnt !== 1'b0) begin bad++; $display("FAIL rst_first_gnt got=%b exp=0", A_Gnt); end
        step();
        model_eval(); @(negedge Clk);
        total++; if (A_Gnt !== 1'b1) begin bad++; $display("FAIL rst_mid_gnt got=%b exp=1", A_Gnt); end
        Reset = 1'b0; #1;
        total++; if ({A_Gnt, B_Gnt, A_Ack, B_Ack, Mem_En, Mem_Write_EN} !== 6'b0) begin
            bad++; $display("FAIL rst_async got=%b exp=000000", {A_Gnt, B_Gnt, A_Ack, B_Ack, Mem_En, Mem_Write_EN}); end
        total++; if (Mem_Address !== 8'h00) begin bad++; $display("FAIL rst_addr got=%h exp=00", Mem_Address); end
        model_reset();
        @(posedge Clk); #1;
        total++; if ({A_Ack, A_Gnt, Mem_En} !== 3'b0) begin
            bad++; $display("FAIL rst_held got=%b exp=000", {A_Ack, A_Gnt, Mem_En}); end
        A_Req = 1'b0;
        @(negedge Clk); Reset = 1'b1;
        @(posedge Clk); #1;
        model_eval(); @(negedge Clk);
        total++; if ({A_Gnt, A_Ack, B_Gnt, B_Ack, Mem_En} !== 5'b0) begin
            bad++; $display("FAIL rst_release got=%b exp=00000", {A_Gnt, A_Ack, B_Gnt, B_Ack, Mem_En}); end
        step();
    endtask

    task automatic test_single_read();
        A_Req = 1'b1; A_Wr = 1'b0; A_Addr = 8'h10; A_DIn = 8'h00;
        model_eval(); @(negedge Clk);
        total++; if (A_Gnt !== 1'b0) begin bad++; $display("FAIL rd_req_gnt got=%b exp=0", A_Gnt); end
        total++; if (CPU_Stall !== 1'b1) begin bad++; $display("FAIL rd_req_stall got=%b exp=1", CPU_Stall); end
        step();
        model_eval(); @(negedge Clk);
        total++; if (A_Gnt !== 1'b1) begin bad++; $display("FAIL rd_gnt got=%b exp=1", A_Gnt); end
        total++; if (CPU_Stall !== 1'b0) begin bad++; $display("FAIL rd_gnt_stall got=%b exp=0", CPU_Stall); end
        total++; if ({Mem_En, Mem_Write_EN, Mem_Address} !== {2'b10, 8'h10}) begin
            bad++; $display("FAIL rd_bus got=%b%b %h exp=10 10", Mem_En, Mem_Write_EN, Mem_Address); end
        step();
        A_Req = 1'b0;
        model_eval(); @(negedge Clk);
        total++; if (A_Ack !== 1'b1) begin bad++; $display("FAIL rd_ack got=%b exp=1", A_Ack); end
        total++; if (A_DOut !== 8'h5A) begin bad++; $display("FAIL rd_data got=%h exp=5a", A_DOut); end
        total++; if (CPU_Stall !== 1'b0) begin bad++; $display("FAIL rd_ack_stall got=%b exp=0", CPU_Stall); end
        step();
        model_eval(); @(negedge Clk);
        total++; if ({A_Ack, A_DOut} !== 9'h0) begin bad++; $display("FAIL rd_after got=%b %h exp=0 00", A_Ack, A_DOut); end
        idle_cycles(2);
    endtask

    task automatic test_contention();
        int seq [4];
        int exp_seq [4];
        int n;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        if (RR) begin exp_seq[0] = 2; exp_seq[1] = 1; exp_seq[2] = 2; exp_seq[3] = 1; end
        else    begin exp_seq[0] = 1; exp_seq[1] = 2; exp_seq[2] = 1; exp_seq[3] = 2; end
        n = 0;
        A_Req = 1'b1; A_Wr = 1'b0; A_Addr = 8'h11;
        B_Req = 1'b1; B_Wr = 1'b0; B_Addr = 8'h12; B_Lock = 1'b0;
        for (int c = 0; c < 12 && n < 4; c++) begin
            model_eval(); @(negedge Clk);
            total++; if ((A_Gnt && B_Gnt) || A_Gnt !== e_ga) begin
                bad++; $display("FAIL cont_gnt cyc=%0d got=%b%b exp=%b%b", c, A_Gnt, B_Gnt, e_ga, e_gb); end
            if (A_Gnt) begin seq[n] = 1; n++; end
            else if (B_Gnt) begin seq[n] = 2; n++; end
            step();
        end
        for (int i = 0; i < 4; i++) begin
            total++; if (seq[i] != exp_seq[i]) begin
                bad++; $display("FAIL cont_order idx=%0d got=%0d exp=%0d", i, seq[i], exp_seq[i]); end
        end
        idle_cycles(2);
    endtask

    task automatic test_burst();
        int  k;
        int  pend_cnt;
        int  cnt_at_a;
        bit  a_raised, a_done, b_after_a, ga, gb;
        k = 0; pend_cnt = 0; cnt_at_a = -1;
        a_raised = 0; a_done = 0; b_after_a = 0;
        B_Lock = 1'b1; B_Req = 1'b1; B_Wr = 1'b1;
        for (int c = 0; c < 40 && k < 8; c++) begin
            B_Addr = 8'(8'h20 + k);
            B_DIn  = 8'(8'hC0 + k);
            if (k == 2 && !a_raised) begin
                A_Req = 1'b1; A_Wr = 1'b0; A_Addr = 8'h05; a_raised = 1;
            end
            model_eval(); @(negedge Clk);
            total++; if (A_Gnt !== e_ga) begin bad++; $display("FAIL burst_a_gnt cyc=%0d got=%b exp=%b", c, A_Gnt, e_ga); end
            total++; if (B_Gnt !== e_gb) begin bad++; $display("FAIL burst_b_gnt cyc=%0d got=%b exp=%b", c, B_Gnt, e_gb); end
            if (B_Gnt && A_Req) pend_cnt++;
            if (A_Gnt) begin cnt_at_a = pend_cnt; a_done = 1; end
            if (B_Gnt && a_done) b_after_a = 1;
            ga = A_Gnt; gb = B_Gnt;
            step();
            if (gb) k++;
            if (ga) A_Req = 1'b0;
        end
        idle_cycles(2);
        total++; if (k != 8) begin bad++; $display("FAIL burst_done got=%0d exp=8", k); end
        total++; if (cnt_at_a != MAXB) begin bad++; $display("FAIL burst_limit got=%0d exp=%0d", cnt_at_a, MAXB); end
        total++; if (!b_after_a) begin bad++; $display("FAIL burst_resume got=0 exp=1"); end
        for (int i = 0; i < 8; i++) begin
            total++; if (mem[8'h20 + i] !== 8'(8'hC0 + i)) begin
                bad++; $display("FAIL burst_mem addr=%h got=%h exp=%h", 8'h20 + i, mem[8'h20 + i], 8'(8'hC0 + i)); end
        end
    endtask

    task automatic test_drop();
        B_Req = 1'b1; B_Wr = 1'b0; B_Addr = 8'h30; B_Lock = 1'b0;
        model_eval(); @(negedge Clk);
        total++; if (B_Gnt !== 1'b0) begin bad++; $display("FAIL drop_req_gnt got=%b exp=0", B_Gnt); end
        step();
        B_Req = 1'b0;
        model_eval(); @(negedge Clk);
        total++; if ({B_Gnt, Mem_En} !== 2'b00) begin bad++; $display("FAIL drop_owned got=%b%b exp=00", B_Gnt, Mem_En); end
        step();
        B_Req = 1'b1;
        model_eval(); @(negedge Clk);
        total++; if ({B_Ack, B_Gnt} !== 2'b00) begin bad++; $display("FAIL drop_idle got=%b%b exp=00", B_Ack, B_Gnt); end
        step();
        model_eval(); @(negedge Clk);
        total++; if (B_Gnt !== 1'b1) begin bad++; $display("FAIL drop_regrant got=%b exp=1", B_Gnt); end
        step();
        B_Req = 1'b0;
        model_eval(); @(negedge Clk);
        total++; if ({B_Ack, B_DOut} !== {1'b1, e_dout_b}) begin
            bad++; $display("FAIL drop_ack got=%b %h exp=1 %h", B_Ack, B_DOut, e_dout_b); end
        idle_cycles(2);
    endtask

    task automatic test_back_to_back();
        A_Req = 1'b1; A_Wr = 1'b1; A_Addr = 8'h40; A_DIn = 8'h33;
        model_eval(); @(negedge Clk);
        step();
        model_eval(); @(negedge Clk);
        total++; if ({A_Gnt, Mem_Write_EN} !== 2'b11) begin bad++; $display("FAIL b2b_wr got=%b%b exp=11", A_Gnt, Mem_Write_EN); end
        step();
        A_Wr = 1'b0;
        model_eval(); @(negedge Clk);
        total++; if ({A_Gnt, Mem_Write_EN, A_Ack} !== 3'b101) begin
            bad++; $display("FAIL b2b_rd got=%b%b%b exp=101", A_Gnt, Mem_Write_EN, A_Ack); end
        step();
        A_Req = 1'b0;
        model_eval(); @(negedge Clk);
        total++; if ({A_Ack, A_DOut} !== {1'b1, 8'h33}) begin
            bad++; $display("FAIL b2b_data got=%b %h exp=1 33", A_Ack, A_DOut); end
        idle_cycles(2);
    endtask

    task automatic test_random();
        bit ag, bg;
        ag = 0; bg = 0;
        for (int c = 0; c < 600; c++) begin
            if (!A_Req || ag) begin
                A_Req = 1'($urandom_range(0, 1)); A_Wr = 1'($urandom_range(0, 1));
                A_Addr = 8'($urandom_range(0, 31)); A_DIn = 8'($urandom);
            end else if ($urandom_range(0, 15) == 0) A_Req = 1'b0;
            if (!B_Req || bg) begin
                B_Req = 1'($urandom_range(0, 1)); B_Wr = 1'($urandom_range(0, 1));
                B_Addr = 8'($urandom_range(0, 31)); B_DIn = 8'($urandom);
            end else if ($urandom_range(0, 15) == 0) B_Req = 1'b0;
            if ($urandom_range(0, 7) == 0) B_Lock = 1'($urandom_range(0, 1));
            model_eval(); @(negedge Clk);
            total++; if (A_Gnt !== e_ga) begin bad++; $display("FAIL rnd_a_gnt cyc=%0d got=%b exp=%b", c, A_Gnt, e_ga); end
            total++; if (B_Gnt !== e_gb) begin bad++; $display("FAIL rnd_b_gnt cyc=%0d got=%b exp=%b", c, B_Gnt, e_gb); end
            total++; if (A_Ack !== e_ack_a) begin bad++; $display("FAIL rnd_a_ack cyc=%0d got=%b exp=%b", c, A_Ack, e_ack_a); end
            total++; if (B_Ack !== e_ack_b) begin bad++; $display("FAIL rnd_b_ack cyc=%0d got=%b exp=%b", c, B_Ack, e_ack_b); end
            total++; if (A_DOut !== e_dout_a) begin bad++; $display("FAIL rnd_a_dout cyc=%0d got=%h exp=%h", c, A_DOut, e_dout_a); end
            total++; if (B_DOut !== e_dout_b) begin bad++; $display("FAIL rnd_b_dout cyc=%0d got=%h exp=%h", c, B_DOut, e_dout_b); end
            total++; if (CPU_Stall !== e_stall) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, CPU_Stall, e_stall); end
            total++; if (Mem_En !== e_en) begin bad++; $display("FAIL rnd_en cyc=%0d got=%b exp=%b", c, Mem_En, e_en); end
            total++; if (Mem_Write_EN !== e_we) begin bad++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", c, Mem_Write_EN, e_we); end
            total++; if (Mem_Address !== e_addr) begin bad++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", c, Mem_Address, e_addr); end
            total++; if (Mem_DIn !== e_din) begin bad++; $display("FAIL rnd_din cyc=%0d got=%h exp=%h", c, Mem_DIn, e_din); end
            ag = A_Gnt; bg = B_Gnt;
            step();
        end
        idle_cycles(2);
    endtask

    initial begin
        total = 0; bad = 0;
        Reset = 1'b0; mem_load = 1'b1;
        A_Req = 1'b0; A_Wr = 1'b0; A_Addr = '0; A_DIn = '0;
        B_Req = 1'b0; B_Wr = 1'b0; B_Addr = '0; B_DIn = '0; B_Lock = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = seed(i);
        model_reset();
        @(posedge Clk); #1;
        mem_load = 1'b0;
        test_reset();
        test_single_read();
        test_contention();
        test_burst();
        test_drop();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
